// File: rtl/otg_hpi_pkg.sv
// otg_hpi_pkg: shared HPI register map, sequencer states and default timing
package otg_hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int DEF_SETUP_CYC    = 1;
    localparam int DEF_STROBE_CYC   = 3;
    localparam int DEF_HOLD_CYC     = 1;
    localparam int DEF_RECOVERY_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } hpi_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return m;
    endfunction

endpackage

// File: rtl/otg_hpi_sequencer.sv
// otg_hpi_sequencer: CY7C67200 HPI bus timing sequencer with single and memory (address+data) ops
module otg_hpi_sequencer
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int STROBE_CYC   = DEF_STROBE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic [1:0]  req_reg,
    input  logic [15:0] req_mem_addr,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    localparam int CNT_W = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC)) + 1;
    localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD   = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LD = CNT_W'(RECOVERY_CYC - 1);

    hpi_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             l_write, l_mem, phase;
    logic [1:0]       l_reg;
    logic [15:0]      l_mem_addr, l_wdata;
    logic             addr_phase, cur_write, last, active, final_end;

    // Phase A of a memory op is always the ADDRESS-register write
    assign addr_phase = l_mem && !phase;
    assign cur_write  = addr_phase ? 1'b1 : l_write;
    assign last       = (cnt == '0);
    assign active     = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
    assign final_end  = (state == ST_RECOVER) && last && !addr_phase;

    assign ack          = final_end;
    assign busy         = (state != ST_IDLE);
    assign otg_cs_n     = !active;
    assign otg_rd_n     = !((state == ST_STROBE) && !cur_write);
    assign otg_wr_n     = !((state == ST_STROBE) && cur_write);
    assign otg_data_oe  = active && cur_write;
    assign otg_addr     = l_mem ? (phase ? HPI_DATA : HPI_ADDRESS) : l_reg;
    assign otg_data_out = addr_phase ? l_mem_addr : l_wdata;

    // Next state and phase counter: each timed state reloads the shared down-counter
    always_comb begin
        state_d = state;
        cnt_d   = (cnt == '0) ? '0 : cnt - 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_SETUP: if (last) begin
                state_d = ST_STROBE;
                cnt_d   = STROBE_LD;
            end
            ST_STROBE: if (last) begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LD;
            end
            ST_HOLD: if (last) begin
                state_d = ST_RECOVER;
                cnt_d   = RECOVERY_LD;
            end
            ST_RECOVER: if (last) begin
                state_d = addr_phase ? ST_SETUP : ST_IDLE;
                cnt_d   = addr_phase ? SETUP_LD : '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, request latch, memory-op phase flag and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            l_write    <= 1'b0;
            l_mem      <= 1'b0;
            l_reg      <= HPI_DATA;
            l_mem_addr <= '0;
            l_wdata    <= '0;
            phase      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == ST_IDLE && req) begin
                l_write    <= req_write;
                l_mem      <= req_mem;
                l_reg      <= req_reg;
                l_mem_addr <= req_mem_addr;
                l_wdata    <= req_wdata;
                phase      <= 1'b0;
            end
            if (state == ST_RECOVER && last && addr_phase)
                phase <= 1'b1;
            if (state == ST_STROBE && last && !cur_write)
                rdata <= otg_data_in;
        end
    end

endmodule

// File: doc/otg_hpi_sequencer.md
Name: otg_hpi_sequencer

Overview:
- Bus sequencer for the CY7C67200 OTG controller's Host Port Interface (HPI). It sits between a single requester (Nios-side glue or a hardware engine) and the HPI pins.
- Generates cs_n/rd_n/wr_n timing with programmable setup/strobe/hold/recovery phases, drives the data bus on writes and captures read data.
- Also supports a two-access "memory" operation: an HPI ADDRESS write followed by an HPI DATA read or write, acknowledged once.

Parameters:
- SETUP_CYC, 1, cycles cs_n low with address valid before the strobe (>=1)
- STROBE_CYC, 3, cycles rd_n/wr_n held low (>=1)
- HOLD_CYC, 1, cycles after strobe release with cs_n low and write data held (>=1)
- RECOVERY_CYC, 2, cycles cs_n high before the next access (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request; level, sampled only in IDLE
- req_write  in  1  1=write, 0=read
- req_mem  in  1  1=memory op (ADDRESS write then DATA access); req_reg ignored
- req_reg  in  2  HPI register for single op: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- req_mem_addr  in  16  CY16 address for memory op
- req_wdata  in  16  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  16  last read data; valid from the ack cycle until the next read completes
- busy  out  1  operation in progress
- otg_addr  out  2  HPI address pins
- otg_cs_n  out  1  chip select
- otg_rd_n  out  1  read strobe
- otg_wr_n  out  1  write strobe
- otg_data_out  out  16  data driven to the tristate pad
- otg_data_oe  out  1  pad output enable
- otg_data_in  in  16  data from the pad

Behaviour:
- Reset values: ack=0, busy=0, rdata=0, otg_addr=0, otg_cs_n=1, otg_rd_n=1, otg_wr_n=1, otg_data_out=0, otg_data_oe=0. State is IDLE.
- Reset mid-operation: on the next edge, strobes and cs_n go high, oe goes low, state returns to IDLE, no ack is issued, and rdata is not updated.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. Each non-IDLE state lasts exactly its parameter in cycles, counted by a shared down-counter.
- Accept: in IDLE with req=1, all req_* fields are latched and the FSM enters SETUP on the next cycle; busy=1 from that cycle. req in any other state is ignored.
- Pin outputs by state:
  - SETUP: cs_n=0, otg_addr=target, rd_n=wr_n=1, oe=write.
  - STROBE: as SETUP, plus rd_n=0 (read) or wr_n=0 (write).
  - HOLD: strobes high, cs_n=0, oe and data unchanged.
  - RECOVER: cs_n=1, oe=0.
  - IDLE: otg_addr and otg_data_out keep their last values.
- Read capture: rdata <= otg_data_in on the clock edge that ends the last STROBE cycle.
- Single-op latency: accepted at cycle T, ack=1 at cycle T+S+P+H+R (the last RECOVER cycle). busy falls with ack.
- Next accept: earliest at T+S+P+H+R+1. A requester that keeps req high after ack gets a back-to-back operation.
- Memory op:
  - Phase A: write req_mem_addr to reg 2 (ADDRESS), full S/P/H/R sequence.
  - Phase B: the DATA (reg 0) access with req_write/req_wdata, full sequence.
  - One ack only, at the end of Phase B; no ack between phases. busy stays high across both. Latency is 2*(S+P+H+R).
  - A phase flag register selects the target and data for each phase.
- Counter width: clog2 of the maximum parameter, plus 1. Parameters are constants; no runtime change.

Decomposition:
- Shared package otg_hpi_pkg:
  - HPI register constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3
  - FSM state enumeration
  - default timing constants
- A sub-module is not warranted: one FSM plus one counter. The pad tristate stays in the top-level pin wrapper.

Test Plan:
- Reset held for 3 cycles during STROBE of a write -> next cycle cs_n=1, wr_n=1, oe=0, busy=0; no ack ever issued.
- Single write, reg=1, wdata=16'hA5C3, defaults:
  - accepted at cycle 0
  - cs_n low cycles 1-5, wr_n low cycles 2-4, otg_addr=1
  - oe high cycles 1-5 with data A5C3
  - ack at cycle 7 only
- Single read, reg=3, otg_data_in=16'h1234 during STROBE (changed to 16'hFFFF after) -> rd_n low cycles 2-4, rdata=1234 from cycle 5, ack at cycle 7.
- Memory read, mem_addr=16'h1000, pad returns 16'hBEEF in Phase B:
  - Phase A writes 1000 to addr 2 (wr_n low cycles 2-4)
  - Phase B reads addr 0 (rd_n low cycles 9-11)
  - single ack at cycle 14; rdata=BEEF
- req held high continuously over two ops -> ack at 7, second op SETUP at 9, second ack at 15; no extra or missing acks.
- req asserted while busy with a changed req_reg -> ignored; latched fields of the in-flight op unchanged on the pins.
